// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: fetch state encoding,
// reset/bubble constants and small PC arithmetic helpers.
package instruction_fetch_unit_pkg;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_KILL  = 2'd2;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR     = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Wraps modulo 2^32 by construction of the 32-bit add.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register: holds {pc, instr, valid}; flush inserts a bubble,
// load captures a new instruction, otherwise contents are held.
module ifid_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Next contents: flush wins over load; bubbles keep the last PC.
    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (load_i) begin
            ifid_d.pc    = pc_i;
            ifid_d.instr = instr_i;
            ifid_d.valid = 1'b1;
        end else begin
            ifid_d = ifid_q;
        end
    end

    // Storage with synchronous reset to an empty bubble at PC 0.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ifid_q.pc    <= 32'h0000_0000;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign pc_o    = ifid_q.pc;
    assign instr_o = ifid_q.instr;
    assign valid_o = ifid_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads with a busy-wait
// handshake, feeds IF/ID, parks a word on decode stall and handles redirects.
// Optional performance counters are enabled with `define IFETCH_PERF_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_INSTRUCTION,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_INSTRUCTION,
    output logic        IFID_VALID
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] STALL_COUNT
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        read_q, read_d;
    logic [31:0] kill_target_q, kill_target_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic        complete_s;
    logic [31:0] target_s;
    logic        ifid_load_s;
    logic        ifid_flush_s;
    logic [31:0] ifid_pc_s;
    logic [31:0] ifid_instr_s;

    assign complete_s = read_q & ~IMEM_BUSYWAIT;
    assign target_s   = align_word(BRANCH_TARGET);

    // Fetch sequencing: redirect beats completion beats stall handling.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_target_d = kill_target_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        ifid_load_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        ifid_pc_s     = pc_q;
        ifid_instr_s  = IMEM_INSTRUCTION;
        case (state_q)
            S_FETCH: begin
                if (BRANCH_TAKEN) begin
                    ifid_flush_s = 1'b1;
                    // Only an outstanding, incomplete read forces the kill path.
                    if (complete_s || !read_q) begin
                        pc_d = target_s;
                    end else begin
                        kill_target_d = target_s;
                        state_d       = S_KILL;
                    end
                end else if (complete_s) begin
                    pc_d = pc_next(pc_q);
                    if (STALL) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = IMEM_INSTRUCTION;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_load_s = 1'b1;
                    end
                end else if (!STALL) begin
                    ifid_flush_s = 1'b1;
                end else begin
                    ifid_flush_s = 1'b0;
                end
            end
            S_HOLD: begin
                if (BRANCH_TAKEN) begin
                    ifid_flush_s = 1'b1;
                    pc_d         = target_s;
                    state_d      = S_FETCH;
                end else if (!STALL) begin
                    ifid_load_s  = 1'b1;
                    ifid_pc_s    = hold_pc_q;
                    ifid_instr_s = hold_instr_q;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_KILL: begin
                if (BRANCH_TAKEN) begin
                    ifid_flush_s = 1'b1;
                    // A redirect landing on the abandoned read's completion goes straight there.
                    if (complete_s) begin
                        pc_d    = target_s;
                        state_d = S_FETCH;
                    end else begin
                        kill_target_d = target_s;
                    end
                end else begin
                    ifid_flush_s = !STALL;
                    if (complete_s) begin
                        pc_d    = kill_target_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_KILL;
                    end
                end
            end
            default: begin
                state_d      = S_FETCH;
                ifid_flush_s = 1'b1;
            end
        endcase
    end

    assign read_d = (state_d != S_HOLD);

    // State, PC, kill target and hold buffer; reset idles READ for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            read_q        <= 1'b0;
            kill_target_q <= 32'h0000_0000;
            hold_pc_q     <= 32'h0000_0000;
            hold_instr_q  <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            read_q        <= read_d;
            kill_target_q <= kill_target_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
        end
    end

    assign IMEM_READ    = read_q;
    assign IMEM_ADDRESS = pc_q;

    ifid_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk_i   (CLK),
        .srst_i  (RESET),
        .load_i  (ifid_load_s),
        .flush_i (ifid_flush_s),
        .pc_i    (ifid_pc_s),
        .instr_i (ifid_instr_s),
        .pc_o    (IFID_PC),
        .instr_o (IFID_INSTRUCTION),
        .valid_o (IFID_VALID)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;
    logic        deliver_s;

    // Killed and redirected words never reach IF/ID or the hold buffer.
    assign deliver_s = (state_q == S_FETCH) && complete_s && !BRANCH_TAKEN;

    // Saturating delivery and memory-wait counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_count_q <= 32'h0000_0000;
            stall_count_q <= 32'h0000_0000;
        end else begin
            if (deliver_s) begin
                fetch_count_q <= sat_inc(fetch_count_q);
            end else begin
                fetch_count_q <= fetch_count_q;
            end
            if (read_q && IMEM_BUSYWAIT) begin
                stall_count_q <= sat_inc(stall_count_q);
            end else begin
                stall_count_q <= stall_count_q;
            end
        end
    end

    assign FETCH_COUNT = fetch_count_q;
    assign STALL_COUNT = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table for
// the corner cases, then randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        busy;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = memw(imem_addr);

    instruction_fetch_unit dut (
        .CLK              (clk),
        .RESET            (rst),
        .IMEM_READ        (imem_read),
        .IMEM_ADDRESS     (imem_addr),
        .IMEM_INSTRUCTION (imem_instr),
        .IMEM_BUSYWAIT    (busy),
        .STALL            (stall),
        .BRANCH_TAKEN     (br),
        .BRANCH_TARGET    (tgt),
        .IFID_PC          (ifid_pc),
        .IFID_INSTRUCTION (ifid_instr),
        .IFID_VALID       (ifid_valid)
`ifdef IFETCH_PERF_EN
        ,
        .FETCH_COUNT      (fetch_count),
        .STALL_COUNT      (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic b, input logic s, input logic t, input logic [31:0] g);
        @(negedge clk);
        rst   = r;
        busy  = b;
        stall = s;
        br    = t;
        tgt   = g;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, busy, stall, br;
        logic [31:0] tgt;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic b, input logic s, input logic t, input logic [31:0] g,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.busy = b; v.stall = s; v.br = t; v.tgt = g;
        v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        vq.push_back(v);
    endtask

    // Behavioural model: flags for "word parked" and "discarding a read".
    logic        m_started, m_parked, m_killing, m_if_valid;
    logic [31:0] m_pc, m_park_pc, m_kill_tgt, m_if_pc;
    logic [31:0] m_fetch_cnt, m_stall_cnt;

    task automatic model_step(input logic r, input logic b, input logic s, input logic t, input logic [31:0] g);
        logic        reading, done;
        logic [31:0] ga;
        ga = g & ~32'd3;
        if (r) begin
            m_started = 1'b0; m_parked = 1'b0; m_killing = 1'b0; m_if_valid = 1'b0;
            m_pc = 32'd0; m_park_pc = 32'd0; m_kill_tgt = 32'd0; m_if_pc = 32'd0;
            m_fetch_cnt = 32'd0; m_stall_cnt = 32'd0;
            return;
        end
        reading = m_started && !m_parked;
        done    = reading && !b;
        if (reading && b && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (t) begin
            m_if_valid = 1'b0;
            if (m_parked) begin
                m_parked = 1'b0;
                m_pc     = ga;
            end else if (m_killing) begin
                if (done) begin m_killing = 1'b0; m_pc = ga; end
                else m_kill_tgt = ga;
            end else if (done || !reading) begin
                m_pc = ga;
            end else begin
                m_killing  = 1'b1;
                m_kill_tgt = ga;
            end
        end else if (m_parked) begin
            if (!s) begin m_if_valid = 1'b1; m_if_pc = m_park_pc; m_parked = 1'b0; end
        end else if (m_killing) begin
            if (done) begin m_killing = 1'b0; m_pc = m_kill_tgt; end
            if (!s) m_if_valid = 1'b0;
        end else if (done) begin
            if (m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt++;
            if (s) begin m_parked = 1'b1; m_park_pc = m_pc; end
            else begin m_if_valid = 1'b1; m_if_pc = m_pc; end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_if_valid = 1'b0;
        end
        m_started = 1'b1;
    endtask

    initial begin
        rst = 1'b1; busy = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'd0;

        // rst busy stall br tgt | read addr valid pc
        add(1,0,0,0,32'h0,         0,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h4,1,32'h0);
        add(0,0,0,0,32'h0,         1,32'h8,1,32'h4);
        add(0,1,0,0,32'h0,         1,32'h8,0,32'h0);
        add(0,1,0,0,32'h0,         1,32'h8,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'hC,1,32'h8);
        add(0,0,0,0,32'h0,         1,32'h10,1,32'hC);
        add(1,0,0,0,32'h0,         0,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h4,1,32'h0);
        add(0,0,1,0,32'h0,         0,32'h8,1,32'h0);
        add(0,0,1,0,32'h0,         0,32'h8,1,32'h0);
        add(0,0,1,0,32'h0,         0,32'h8,1,32'h0);
        add(0,0,0,0,32'h0,         1,32'h8,1,32'h4);
        add(0,0,0,0,32'h0,         1,32'hC,1,32'h8);
        add(0,0,0,0,32'h0,         1,32'h10,1,32'hC);
        add(0,1,0,1,32'h40,        1,32'h10,0,32'h0);
        add(0,1,0,0,32'h0,         1,32'h10,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h40,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h44,1,32'h40);
        add(0,1,0,1,32'h60,        1,32'h44,0,32'h0);
        add(0,1,0,1,32'h83,        1,32'h44,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h80,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h84,1,32'h80);
        add(0,1,0,0,32'h0,         1,32'h84,0,32'h0);
        add(1,1,0,0,32'h0,         0,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h0,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h4,1,32'h0);
        add(0,0,0,1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h0,1,32'hFFFF_FFFC);
        add(0,0,0,0,32'h0,         1,32'h4,1,32'h0);
        add(0,0,1,0,32'h0,         0,32'h8,1,32'h0);
        add(0,0,1,1,32'h200,       1,32'h200,0,32'h0);
        add(0,0,0,0,32'h0,         1,32'h204,1,32'h200);
        add(0,1,1,0,32'h0,         1,32'h204,1,32'h200);
        add(0,0,0,0,32'h0,         1,32'h208,1,32'h204);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].busy, vq[i].stall, vq[i].br, vq[i].tgt);
            check($sformatf("v%0d read", i), {31'd0, imem_read}, {31'd0, vq[i].exp_read});
            check($sformatf("v%0d addr", i), imem_addr, vq[i].exp_addr);
            check($sformatf("v%0d valid", i), {31'd0, ifid_valid}, {31'd0, vq[i].exp_valid});
            check($sformatf("v%0d instr", i), ifid_instr, vq[i].exp_valid ? memw(vq[i].exp_pc) : NOP);
            if (vq[i].exp_valid || vq[i].rst)
                check($sformatf("v%0d ifid_pc", i), ifid_pc, vq[i].exp_pc);
        end

        for (int c = 0; c < 3000; c++) begin
            logic        r, b, s, t;
            logic [31:0] g;
            r = (c == 0) || ($urandom_range(0, 99) == 0);
            b = ($urandom_range(0, 9) < 4);
            s = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 7) == 0);
            g = $urandom;
            apply(r, b, s, t, g);
            model_step(r, b, s, t, g);
            check("rnd read", {31'd0, imem_read}, {31'd0, m_started && !m_parked});
            check("rnd addr", imem_addr, m_pc);
            check("rnd valid", {31'd0, ifid_valid}, {31'd0, m_if_valid});
            check("rnd instr", ifid_instr, m_if_valid ? memw(m_if_pc) : NOP);
            if (m_if_valid) check("rnd ifid_pc", ifid_pc, m_if_pc);
`ifdef IFETCH_PERF_EN
            check("rnd fetch_count", fetch_count, m_fetch_cnt);
            check("rnd stall_count", stall_count, m_stall_cnt);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and issues word-aligned read requests to the instruction memory, waiting on its busy-wait handshake.
- Loads fetched words into the IF/ID pipeline register.
- Handles decode stalls through a one-entry hold buffer, and branch redirects, including redirects that arrive while a fetch is still pending.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (ADDI x0,x0,0) driven on IFID_INSTRUCTION when invalid.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- IMEM_READ  output  1  read request to instruction memory
- IMEM_ADDRESS  output  32  byte address of the requested word; bits [1:0] always 00
- IMEM_INSTRUCTION  input  32  word returned by memory
- IMEM_BUSYWAIT  input  1  memory busy; a read completes on an edge with IMEM_READ=1 and IMEM_BUSYWAIT=0
- STALL  input  1  hazard unit: hold IF/ID contents
- BRANCH_TAKEN  input  1  redirect request from EX
- BRANCH_TARGET  input  32  redirect address; bits [1:0] forced to 00 internally
- IFID_PC  output  32  PC of the instruction held in IF/ID
- IFID_INSTRUCTION  output  32  instruction held in IF/ID
- IFID_VALID  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (RESET=1 at a rising edge):
  - pc=RESET_PC, state=FETCH.
  - IMEM_READ=0 for that cycle; asserted from the first cycle after reset.
  - IFID_VALID=0, IFID_INSTRUCTION=NOP_INSTR, IFID_PC=0, hold buffer cleared, kill target=0.
  - Reset mid-fetch abandons the request; the returning word is ignored.
- Protocol:
  - IMEM_ADDRESS=pc. Address is stable while IMEM_READ=1 until completion; no change mid-request, even on redirect.
  - Back-to-back requests are allowed: READ stays high with the new address on the cycle after completion.
- FETCH state (IMEM_READ=1):
  - Completion with no redirect and STALL=0: IF/ID <= {pc, IMEM_INSTRUCTION, valid=1}; pc<=pc+4; stay FETCH.
  - Completion with no redirect and STALL=1: word and pc go to hold buffer; pc<=pc+4; go HOLD.
  - No completion and STALL=0: IFID_VALID<=0, IFID_INSTRUCTION<=NOP_INSTR (bubble).
  - No completion and STALL=1: IF/ID unchanged.
- HOLD state (IMEM_READ=0):
  - STALL=0: hold buffer moves to IF/ID; go FETCH.
- KILL state (IMEM_READ=1, address = old pc):
  - Waits for the abandoned read to complete, then discards the word, sets pc<=kill_target and goes FETCH.
  - IF/ID receives bubbles meanwhile (when STALL=0).
- Redirect (BRANCH_TAKEN=1) has priority over STALL and over completion. IF/ID is flushed to valid=0/NOP_INSTR on the same edge.
  - FETCH with completion on the same edge: word discarded; pc<=target; stay FETCH.
  - FETCH without completion: kill_target<=target; go KILL.
  - HOLD: buffer discarded; pc<=target; go FETCH.
  - KILL: kill_target overwritten with the newest target.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined: adds outputs FETCH_COUNT[31:0] and STALL_COUNT[31:0], both zeroed on reset and saturating at all-ones.
  - FETCH_COUNT increments per completion delivered to IF/ID or the hold buffer; killed words are not counted.
  - STALL_COUNT increments each cycle with IMEM_READ=1 and IMEM_BUSYWAIT=1.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: fetch state encoding (FETCH, HOLD, KILL), NOP_INSTR constant, RESET_PC default, PC increment constant 4.
- One sub-module, ifid_register: clocked {pc, instr, valid} holding register with load, hold and flush controls.
- PC logic and the state machine stay in the top module.

Test Plan:
- Zero-wait memory, RESET released: IMEM_ADDRESS steps 0,4,8,12 on consecutive cycles; IFID_PC trails by one cycle with valid=1.
- BUSYWAIT=1 for 2 cycles on address 8: IMEM_ADDRESS is held at 8; 2 bubble cycles (valid=0, 0x00000013); then IFID_PC=8.
- STALL=1 for 3 cycles at completion of address 4: IMEM_READ=0 and IF/ID frozen; after release IFID_PC=4, the next request is 8, and no word is lost.
- BRANCH_TAKEN to 0x40 while a fetch of 0x10 is pending 2 cycles: address held at 0x10 until completion; its word never reaches IF/ID; next request is 0x40.
- Second redirect to 0x80 during KILL, plus target 0x83: next request is 0x80; misalignment is masked.
- RESET asserted mid-wait: next cycle IFID_VALID=0 and IMEM_READ=0; the following cycle requests RESET_PC.
